// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// geometry/latency and the address legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
    localparam int unsigned DEFAULT_LATENCY     = 2;
    localparam int unsigned WORD_BYTES          = 4;
    localparam logic [1:0]  ALIGN_MASK          = 2'b11;

    // Limit is widened to 33 bits so DEPTH_WORDS*4 cannot wrap for large stores.
    function automatic logic addr_is_err(input logic [31:0] addr,
                                         input int unsigned depth_words);
        logic [32:0] limit;
        limit = 33'(depth_words) * 33'(WORD_BYTES);
        return ((addr[1:0] & ALIGN_MASK) != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word store with byte-lane write enables and a combinational
// read path.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // NOTE: the store has no reset branch; contents must survive reset and a
    // resettable array would turn the RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Request/response front end for the data store: captures one request, waits
// LATENCY edges, performs the checked access and holds the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_en_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept;
    logic        access_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // ready_en_q keeps req_ready low in reset and raises it one edge after release.
    assign req_ready  = ready_en_q && (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign access_err = addr_is_err(addr_q, DEPTH_WORDS);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    mem_we  = we_q && !access_err;
                    err_d   = access_err;
                    rdata_d = (we_q || access_err) ? 32'd0 : mem_rdata;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            ready_en_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .idx_i   (addr_q[IDX_W+1:2]),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a behavioural memory model with a response queue,
// directed corner cases, randomized traffic and a LATENCY=1 throughput check.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;
    logic [3:0]  req_wstrb1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wstrb(req_wstrb1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          accept_edge;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] model_mem [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err   = 1'b0;
    bit          in_resp    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait budget expired at cycle %0d, expected the event", name, cyc);
    endtask

    // Reference: legality from plain address arithmetic, store as a word array.
    task automatic model_access(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                output exp_t e);
        e.err         = (addr % 4 != 0) || (addr >= DEPTH * 4);
        e.rdata       = 32'd0;
        e.accept_edge = 0;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) model_mem[addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = model_mem[addr / 4];
            end
        end
    endtask

    // Compare process: every cycle a response is visible it must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            in_resp = 1'b0;
        end else begin
            if (resp_valid) begin
                check("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        cur = exp_q.pop_front();
                        check("resp_rdata", resp_rdata, cur.rdata);
                        check("resp_err", 32'(resp_err), 32'(cur.err));
                        check("latency", 32'(cyc - cur.accept_edge), 32'(LAT));
                        last_rdata = resp_rdata;
                        last_err   = resp_err;
                    end
                end else begin
                    check("hold_rdata", resp_rdata, cur.rdata);
                    check("hold_err", 32'(resp_err), 32'(cur.err));
                end
            end
            in_resp = resp_valid;
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int bp, input bit poke);
        int   t;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) begin
            fail_now("req_accept");
            req_valid = 1'b0;
            return;
        end
        model_access(we, addr, wdata, wstrb, e);
        e.accept_edge = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        t = 0;
        while (!resp_valid && t < 50) begin
            resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        if (!resp_valid) begin
            fail_now("resp_valid");
            resp_ready = 1'b0;
            return;
        end
        resp_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            if (poke) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = 32'($urandom_range(0, DEPTH - 1)) << 2;
                req_wstrb = 4'hF;
            end
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic reset_mid_write();
        int t;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
        req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) begin fail_now("rst_accept"); req_valid = 1'b0; return; end
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_no_resp", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_async_ready", 32'(req_ready), 32'd0);
        check("rst_async_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_release_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_release_ready_high", 32'(req_ready), 32'd1);
    endtask

    logic [31:0] op_addr [6];
    logic [31:0] op_wdata[6];
    logic [31:0] op_rd   [6];
    logic        op_we   [6];
    logic        op_er   [6];

    initial begin
        logic [31:0] a;
        int          t;
        int          prev;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 0;
        req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0; req_wstrb1 = 0; resp_ready1 = 1;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_resp_err", 32'(resp_err), 32'd0);
        check("reset_req_ready_lat1", 32'(req_ready1), 32'd0);
        rst = 1'b1;
        #1;
        check("release_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("release_ready_high", 32'(req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, 1'b0);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        check("wr10_rdata_zero", last_rdata, 32'd0);
        check("wr10_err", 32'(last_err), 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);
        check("rd10_rdata", last_rdata, 32'hDEADBEEF);
        check("rd10_err", 32'(last_err), 32'd0);

        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
        do_req(1'b0, 32'h20, 32'd0, 4'h0, 5, 1'b1);
        check("lanes_rd20", last_rdata, 32'h11BB33DD);
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 1'b0);
        check("wstrb0_err", 32'(last_err), 32'd0);
        do_req(1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0);
        check("wstrb0_rd20", last_rdata, 32'h11BB33DD);

        do_req(1'b1, 32'h0, 32'h01020304, 4'hF, 0, 1'b0);
        do_req(1'b0, 32'h2, 32'd0, 4'h0, 0, 1'b0);
        check("misalign_err", 32'(last_err), 32'd1);
        check("misalign_rdata", last_rdata, 32'd0);
        do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
        check("oor_err", 32'(last_err), 32'd1);
        do_req(1'b0, 32'h0, 32'd0, 4'h0, 0, 1'b0);
        check("oor_word0", last_rdata, 32'h01020304);
        do_req(1'b0, 32'h3FC, 32'd0, 4'h0, 0, 1'b0);
        check("last_word_err", 32'(last_err), 32'd0);

        do_req(1'b1, 32'h30, 32'h5A5A1234, 4'hF, 0, 1'b0);
        reset_mid_write();
        do_req(1'b0, 32'h30, 32'd0, 4'h0, 0, 1'b0);
        check("rst_mid_write_rd30", last_rdata, 32'h5A5A1234);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                1:       a = 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
                2:       a = $urandom | 32'h8000_0000;
                3:       a = 32'h3FC;
                default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                   $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        op_we[0] = 1; op_addr[0] = 32'h40; op_wdata[0] = 32'h11111111; op_rd[0] = 0;            op_er[0] = 0;
        op_we[1] = 1; op_addr[1] = 32'h44; op_wdata[1] = 32'h22222222; op_rd[1] = 0;            op_er[1] = 0;
        op_we[2] = 0; op_addr[2] = 32'h40; op_wdata[2] = 32'h0;        op_rd[2] = 32'h11111111; op_er[2] = 0;
        op_we[3] = 0; op_addr[3] = 32'h44; op_wdata[3] = 32'h0;        op_rd[3] = 32'h22222222; op_er[3] = 0;
        op_we[4] = 0; op_addr[4] = 32'h06; op_wdata[4] = 32'h0;        op_rd[4] = 0;            op_er[4] = 1;
        op_we[5] = 0; op_addr[5] = 32'h40; op_wdata[5] = 32'h0;        op_rd[5] = 32'h11111111; op_er[5] = 0;
        prev = 0;
        @(negedge clk);
        req_valid1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_we1 = op_we[i]; req_addr1 = op_addr[i]; req_wdata1 = op_wdata[i]; req_wstrb1 = 4'hF;
            t = 0;
            while (!req_ready1 && t < 20) begin @(negedge clk); t++; end
            if (!req_ready1) begin fail_now("lat1_accept"); break; end
            @(negedge clk);
            t = 0;
            while (!resp_valid1 && t < 20) begin @(negedge clk); t++; end
            if (!resp_valid1) begin fail_now("lat1_resp"); break; end
            check("lat1_rdata", resp_rdata1, op_rd[i]);
            check("lat1_err", 32'(resp_err1), 32'(op_er[i]));
            if (i > 0) check("lat1_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
        end
        req_valid1 = 1'b0;

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the internal data store; byte capacity is DEPTH_WORDS*4.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: number of clock edges from request acceptance to response.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  initiator has a request on the req_* bus.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data, little-endian byte lanes.
REQ-010 req_wstrb  input  4  byte-lane write enables; bit i enables req_wdata[8i+7:8i].
REQ-011 resp_valid  output  1  response is available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  read data; 0 for writes and for errors.
REQ-014 resp_err  output  1  1 = the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted at a rising edge where req_valid && req_ready; req_we, req_addr, req_wdata and req_wstrb SHALL be captured on that edge.
REQ-018 On acceptance the FSM SHALL go IDLE->WAIT and load a 4-bit counter with LATENCY-1.
REQ-019 In WAIT with counter != 0, each edge SHALL decrement the counter.
REQ-020 In WAIT with counter == 0, the next edge SHALL perform the access, register resp_rdata/resp_err and enter RESP.
REQ-021 resp_valid SHALL be 1 only in RESP; resp_rdata and resp_err SHALL be held stable while resp_valid=1 && resp_ready=0.
REQ-022 An edge in RESP with resp_ready=1 SHALL return the FSM to IDLE; a new request can be accepted no earlier than the following edge.
REQ-023 Cycle timing: for acceptance at edge k, resp_valid SHALL rise after edge k+LATENCY.
REQ-024 Error condition: req_addr[1:0] != 0 (misaligned) or req_addr >= DEPTH_WORDS*4 (out of range) SHALL give resp_err=1 and resp_rdata=0, with no write performed.
REQ-025 A legal read SHALL return the full word at index req_addr[31:2], with resp_err=0.
REQ-026 A legal write SHALL update only the lanes enabled in req_wstrb; wstrb=4'b0000 SHALL be a no-op with resp_err=0.
REQ-027 Every write response SHALL have resp_rdata=0.
REQ-028 The store write SHALL occur exactly once per accepted write, on the WAIT->RESP edge.
REQ-029 req_valid changes while not in IDLE SHALL have no effect on state or store contents.
REQ-030 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-031 While rst=0 the block SHALL be in IDLE with counter=0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=0.
REQ-032 req_ready SHALL become 1 at the first clock edge after rst deasserts.
REQ-033 Reset asserted in WAIT SHALL discard the pending request with no write performed; reset asserted in RESP SHALL drop the response.
REQ-034 Store contents SHALL NOT be cleared by reset.

Structure
REQ-035 A shared package dmem_pkg SHALL hold the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the default DEPTH_WORDS/LATENCY constants and the address-check helper constants.
REQ-036 The store SHALL be a single sub-module dmem_array: single port, synchronous byte-masked write, combinational read, parameterised by DEPTH_WORDS.
REQ-037 The error check and counter SHALL reside in dmem_responder.

Verification
REQ-038 Write then read: write addr 0x10, data 0xDEADBEEF, wstrb 4'hF, then read 0x10 -> resp_rdata=0xDEADBEEF and resp_err=0; resp_valid rises 2 edges after each acceptance.
REQ-039 Byte lanes: write 0x11223344 to 0x20, then write 0xAABBCCDD to 0x20 with wstrb 4'b0101, then read 0x20 -> 0x11BB33DD.
REQ-040 Errors: read 0x02 -> err=1, rdata=0; write to 0x400 (DEPTH 256) -> err=1, and the word at index 0 is unchanged.
REQ-041 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable, req_ready=0, and a req_valid pulse in that window is not accepted.
REQ-042 Reset mid-write: accept a write of 0xCAFEF00D to 0x30, pull rst low in WAIT, release it, then read 0x30 -> the prior value is returned.
REQ-043 LATENCY=1 build: back-to-back reads with resp_ready tied 1 -> one response every 3 cycles, each with correct data.
